acc_feeder: RTL and testbench

//   Initiator for the accumulator core. Buffers operands in a FIFO and streams a

---
 rtl/acc_feeder_if.sv | 41 ++++
 rtl/acc_feeder.sv | 172 +++++++++++++++++
 tb/tb_acc_feeder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/acc_feeder_if.sv
//------------------------------------------------------------------------------
// Module      : acc_feeder_if
// Description : Operand-source, control and accumulator-core signals of acc_feeder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface acc_feeder_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int DEPTH_LOG2    = 4
);
    logic                     wr_en_i;
    logic [IN_DATA_WIDTH-1:0] wr_data_i;
    logic                     full_o;
    logic [DEPTH_LOG2:0]      count_o;
    logic                     start_i;
    logic [DEPTH_LOG2:0]      num_i;
    logic                     busy_o;
    logic                     err_o;
    logic [IN_DATA_WIDTH-1:0] number_o;
    logic                     valid_o;
    logic                     run_o;
    logic                     acc_valid_i;
    logic [DWIDTH-1:0]        acc_result_i;
    logic                     done_o;
    logic [DWIDTH-1:0]        result_o;

    modport slave (
        input  wr_en_i, wr_data_i, start_i, num_i, acc_valid_i, acc_result_i,
        output full_o, count_o, busy_o, err_o, number_o, valid_o, run_o, done_o, result_o
    );

    modport master (
        output wr_en_i, wr_data_i, start_i, num_i, acc_valid_i, acc_result_i,
        input  full_o, count_o, busy_o, err_o, number_o, valid_o, run_o, done_o, result_o
    );
endinterface

`default_nettype wire

// File: rtl/acc_feeder.sv
//------------------------------------------------------------------------------
// Module      : acc_feeder
// Description : FIFO-buffered burst initiator for the accumulator core; counts
//               returned beats and captures the final result with a done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module acc_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int DEPTH_LOG2    = 4
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    acc_feeder_if.slave   bus
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [IN_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]      count_q;
    logic [DEPTH_LOG2:0]      rem_q, rem_d;
    logic [DEPTH_LOG2:0]      ret_q, ret_d;
    logic [DEPTH_LOG2:0]      num_q, num_d;

    logic [IN_DATA_WIDTH-1:0] number_q;
    logic                     valid_q;
    logic                     run_q;
    logic                     err_q;
    logic                     done_q;
    logic [DWIDTH-1:0]        result_q;

    logic w_full, w_push, w_start_ok, w_start_bad, w_issue, w_busy, w_ret_hit;

    assign w_full     = (count_q == FULL_COUNT);
    assign w_push     = bus.wr_en_i && !w_full;
    assign w_start_ok = bus.start_i && (bus.num_i != '0) && (bus.num_i <= count_q);
    assign w_start_bad = (state_q == S_IDLE) && bus.start_i && !w_start_ok;
    assign w_ret_hit  = w_busy && bus.acc_valid_i && ((ret_q + 1'b1) == num_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and burst counters; rem counts beats still to issue after this one
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ret_d   = ret_q;
        num_d   = num_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && w_start_ok) begin
                    num_d   = bus.num_i;
                    ret_d   = '0;
                    rem_d   = bus.num_i - 1'b1;
                    state_d = (bus.num_i == 1) ? S_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == 1) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: ;
            default: state_d = S_IDLE;
        endcase
        if (w_busy && bus.acc_valid_i) begin
            ret_d = ret_q + 1'b1;
        end
        if (w_ret_hit) begin
            state_d = S_IDLE;
        end
    end

    // Output decode
    always_comb begin
        w_issue = 1'b0;
        w_busy  = 1'b0;
        case (state_q)
            S_IDLE: w_issue = w_start_ok;
            S_RUN: begin
                w_issue = 1'b1;
                w_busy  = 1'b1;
            end
            S_WAIT: w_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            ret_q    <= '0;
            num_q    <= '0;
        end else begin
            rem_q <= rem_d;
            ret_q <= ret_d;
            num_q <= num_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_issue) begin
                count_q <= count_q + 1'b1;
            end else if (!w_push && w_issue) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Registered core-facing and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            number_q <= '0;
            valid_q  <= 1'b0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= w_issue;
            run_q   <= w_issue;
            err_q   <= w_start_bad;
            done_q  <= w_ret_hit;
            if (w_issue) begin
                number_q <= mem_q[rd_ptr_q];
            end
            if (w_ret_hit) begin
                result_q <= bus.acc_result_i;
            end
        end
    end

    assign bus.full_o   = w_full;
    assign bus.count_o  = count_q;
    assign bus.busy_o   = w_busy;
    assign bus.err_o    = err_q;
    assign bus.number_o = number_q;
    assign bus.valid_o  = valid_q;
    assign bus.run_o    = run_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_feeder.sv
//------------------------------------------------------------------------------
// Module      : tb_acc_feeder
// Description : Directed self-checking bench for acc_feeder with a same-cycle
//               accumulator core model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_acc_feeder;
    localparam int W  = 8;
    localparam int DW = 32;
    localparam int DL = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [DW-1:0] core_total;

    acc_feeder_if #(.IN_DATA_WIDTH(W), .DWIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    acc_feeder #(.IN_DATA_WIDTH(W), .DWIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Core model: answers in the same cycle with the running total including this beat
    assign bus.acc_valid_i  = bus.valid_o & bus.run_o;
    assign bus.acc_result_i = core_total + DW'(bus.number_o);
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) core_total <= '0;
        else if (bus.valid_o && bus.run_o) core_total <= core_total + DW'(bus.number_o);
    end

    task automatic idle_inputs();
        bus.wr_en_i = 1'b0; bus.wr_data_i = '0; bus.start_i = 1'b0; bus.num_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] v);
        bus.wr_en_i = 1'b1; bus.wr_data_i = v;
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if ({bus.valid_o, bus.run_o, bus.done_o, bus.err_o, bus.busy_o, bus.full_o} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {bus.valid_o, bus.run_o, bus.done_o, bus.err_o, bus.busy_o, bus.full_o}); else n_pass++;
        n_total++; if (bus.count_o !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.count_o); else n_pass++;
        n_total++; if (bus.number_o !== 8'd0 || bus.result_o !== 32'd0)
            $display("FAIL reset_data: got number=%0d result=%0d want 0/0", bus.number_o, bus.result_o); else n_pass++;
    endtask

    task automatic test_basic_burst();
        logic [W-1:0] exp_v [3] = '{8'd5, 8'd7, 8'd9};
        apply_reset();
        push(8'd5); push(8'd7); push(8'd9);
        n_total++; if (bus.count_o !== 5'd3) $display("FAIL basic_count_pre: got %0d want 3", bus.count_o); else n_pass++;
        bus.start_i = 1'b1; bus.num_i = 5'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (bus.valid_o !== 1'b1 || bus.run_o !== 1'b1 || bus.number_o !== exp_v[i] || bus.busy_o !== 1'b1)
                $display("FAIL basic_beat[%0d]: got v=%b r=%b n=%0d b=%b want 1/1/%0d/1", i, bus.valid_o, bus.run_o, bus.number_o, bus.busy_o, exp_v[i]); else n_pass++;
            n_total++; if (bus.done_o !== 1'b0) $display("FAIL basic_early_done[%0d]: got %b want 0", i, bus.done_o); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (bus.done_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd21)
            $display("FAIL basic_done: got d=%b v=%b res=%0d want 1/0/21", bus.done_o, bus.valid_o, bus.result_o); else n_pass++;
        n_total++; if (bus.count_o !== 5'd0 || bus.number_o !== 8'd9)
            $display("FAIL basic_post: got count=%0d number=%0d want 0/9", bus.count_o, bus.number_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 32'd21)
            $display("FAIL basic_pulse: got d=%b b=%b res=%0d want 0/0/21", bus.done_o, bus.busy_o, bus.result_o); else n_pass++;
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            n_total++; if (bus.full_o !== 1'b0) $display("FAIL full_early[%0d]: got %b want 0", i, bus.full_o); else n_pass++;
            push(W'(i + 1));
        end
        n_total++; if (bus.full_o !== 1'b1 || bus.count_o !== 5'd16)
            $display("FAIL full_set: got full=%b count=%0d want 1/16", bus.full_o, bus.count_o); else n_pass++;
        push(8'd99);
        n_total++; if (bus.full_o !== 1'b1 || bus.count_o !== 5'd16)
            $display("FAIL full_drop: got full=%b count=%0d want 1/16", bus.full_o, bus.count_o); else n_pass++;
    endtask

    task automatic test_start_errors();
        apply_reset();
        push(8'd1); push(8'd2);
        bus.start_i = 1'b1; bus.num_i = 5'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_total++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0)
            $display("FAIL err_zero: got err=%b busy=%b want 1/0", bus.err_o, bus.busy_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL err_pulse: got %b want 0", bus.err_o); else n_pass++;
        bus.start_i = 1'b1; bus.num_i = 5'd4;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_total++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.count_o !== 5'd2 || bus.valid_o !== 1'b0)
            $display("FAIL err_over: got err=%b busy=%b count=%0d valid=%b want 1/0/2/0", bus.err_o, bus.busy_o, bus.count_o, bus.valid_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.err_o !== 1'b0 || bus.count_o !== 5'd2)
            $display("FAIL err_after: got err=%b count=%0d want 0/2", bus.err_o, bus.count_o); else n_pass++;
    endtask

    task automatic test_push_during_burst();
        logic [W-1:0] exp_a [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        logic [W-1:0] exp_b [5] = '{8'd50, 8'd60, 8'd61, 8'd62, 8'd63};
        apply_reset();
        push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50);
        bus.start_i = 1'b1; bus.num_i = 5'd4;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en_i = 1'b1; bus.wr_data_i = W'(60 + i);
            @(negedge clk);
            bus.start_i = 1'b0;
            n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== exp_a[i])
                $display("FAIL pdb_beat[%0d]: got v=%b n=%0d want 1/%0d", i, bus.valid_o, bus.number_o, exp_a[i]); else n_pass++;
        end
        bus.wr_en_i = 1'b0;
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b1 || bus.result_o !== 32'd100 || bus.count_o !== 5'd5)
            $display("FAIL pdb_done: got d=%b res=%0d count=%0d want 1/100/5", bus.done_o, bus.result_o, bus.count_o); else n_pass++;
        bus.start_i = 1'b1; bus.num_i = 5'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== exp_b[i])
                $display("FAIL pdb_order[%0d]: got v=%b n=%0d want 1/%0d", i, bus.valid_o, bus.number_o, exp_b[i]); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b1 || bus.result_o !== 32'd396 || bus.count_o !== 5'd0)
            $display("FAIL pdb_done2: got d=%b res=%0d count=%0d want 1/396/0", bus.done_o, bus.result_o, bus.count_o); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        push(8'd11); push(8'd12); push(8'd13); push(8'd14);
        bus.start_i = 1'b1; bus.num_i = 5'd4;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== 8'd12)
            $display("FAIL rmb_beat2: got v=%b n=%0d want 1/12", bus.valid_o, bus.number_o); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if ({bus.valid_o, bus.run_o, bus.done_o, bus.err_o, bus.busy_o} !== 5'b0 || bus.number_o !== 8'd0)
            $display("FAIL rmb_flags: got %b n=%0d want 00000/0", {bus.valid_o, bus.run_o, bus.done_o, bus.err_o, bus.busy_o}, bus.number_o); else n_pass++;
        n_total++; if (bus.count_o !== 5'd0 || bus.result_o !== 32'd0)
            $display("FAIL rmb_count: got count=%0d res=%0d want 0/0", bus.count_o, bus.result_o); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(8'd1); push(8'd2);
        bus.start_i = 1'b1; bus.num_i = 5'd2;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== 8'd1)
            $display("FAIL rmb_new1: got v=%b n=%0d want 1/1", bus.valid_o, bus.number_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== 8'd2)
            $display("FAIL rmb_new2: got v=%b n=%0d want 1/2", bus.valid_o, bus.number_o); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b1 || bus.result_o !== 32'd3)
            $display("FAIL rmb_done: got d=%b res=%0d want 1/3", bus.done_o, bus.result_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_v [3] = '{8'd6, 8'd7, 8'd8};
        apply_reset();
        push(8'd6); push(8'd7); push(8'd8); push(8'd4); push(8'd4);
        bus.start_i = 1'b1; bus.num_i = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            // Second start request lands while the first burst is running
            bus.start_i = (i == 0); bus.num_i = (i == 0) ? 5'd2 : 5'd0;
            n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== exp_v[i] || bus.err_o !== 1'b0)
                $display("FAIL b2b_beat[%0d]: got v=%b n=%0d err=%b want 1/%0d/0", i, bus.valid_o, bus.number_o, bus.err_o, exp_v[i]); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b1 || bus.result_o !== 32'd21 || bus.count_o !== 5'd2 || bus.err_o !== 1'b0)
            $display("FAIL b2b_done1: got d=%b res=%0d count=%0d err=%b want 1/21/2/0", bus.done_o, bus.result_o, bus.count_o, bus.err_o); else n_pass++;
        bus.start_i = 1'b1; bus.num_i = 5'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            n_total++; if (bus.valid_o !== 1'b1 || bus.number_o !== 8'd4 || bus.done_o !== 1'b0)
                $display("FAIL b2b_beat2[%0d]: got v=%b n=%0d d=%b want 1/4/0", i, bus.valid_o, bus.number_o, bus.done_o); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.done_o !== 1'b1 || bus.result_o !== 32'd29 || bus.count_o !== 5'd0)
            $display("FAIL b2b_done2: got d=%b res=%0d count=%0d want 1/29/0", bus.done_o, bus.result_o, bus.count_o); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic_burst();
        test_full();
        test_start_errors();
        test_push_during_burst();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule

`default_nettype wire
